// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, NOP encoding and stage-entry type for pipeline stage registers
package pipe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_PC_W = 32;
  localparam int DEF_CNT_W = 16;
  localparam logic [31:0] NOP_INSN = 32'd0;
  typedef struct packed {
    logic valid;
    logic [DEF_PC_W-1:0] pc;
    logic [DEF_DATA_W-1:0] data;
  } stage_entry_t;
endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_slot: one valid+pc+data register with kill/load/clear/hold controls
module pipe_slot #(
  parameter int PC_W = 32,
  parameter int DATA_W = 32,
  parameter bit USE_FILL = 1'b0,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kill,
  input  logic              load,
  input  logic              clear,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] data
);
  // kill beats load beats clear; kill optionally overwrites the payload with a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc <= '0;
      data <= '0;
    end else if (kill) begin
      valid <= 1'b0;
      if (USE_FILL) data <= FILL;
    end else if (load) begin
      valid <= 1'b1;
      pc <= d_pc;
      data <= d_data;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: handshaked pipeline register with optional skid entry, flush bubble and perf counters
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int PC_W = DEF_PC_W,
  parameter bit SKID = 1'b1,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_INSN),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic s_v, in_fire, out_fire, main_load, main_clear, from_skid, skid_load, skid_clear;
  logic [PC_W-1:0] s_pc;
  logic [DATA_W-1:0] s_data;
  assign in_ready = !freeze && (SKID ? !s_v : (!out_valid || out_ready));
  assign in_fire = in_valid && in_ready;
  assign out_fire = out_valid && out_ready && !freeze;
  assign from_skid = out_fire && s_v;
  assign main_load = from_skid || (in_fire && (!out_valid || out_fire));
  assign main_clear = out_fire && !s_v && !in_fire;
  assign skid_load = in_fire && (s_v || (out_valid && !out_fire));
  assign skid_clear = out_fire && s_v && !in_fire;
  pipe_slot #(.PC_W(PC_W), .DATA_W(DATA_W), .USE_FILL(1'b1), .FILL(NOP_VAL)) u_main (
    .clk(clk), .rst(rst), .kill(flush), .load(main_load), .clear(main_clear),
    .d_pc(from_skid ? s_pc : in_pc), .d_data(from_skid ? s_data : in_data),
    .valid(out_valid), .pc(out_pc), .data(out_data)
  );
  if (SKID) begin : g_skid
    pipe_slot #(.PC_W(PC_W), .DATA_W(DATA_W)) u_skid (
      .clk(clk), .rst(rst), .kill(flush), .load(skid_load), .clear(skid_clear),
      .d_pc(in_pc), .d_data(in_data), .valid(s_v), .pc(s_pc), .data(s_data)
    );
  end else begin : g_noskid
    assign s_v = 1'b0;
    assign s_pc = '0;
    assign s_data = '0;
  end
  // saturating stall and flush counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((freeze || (out_valid && !out_ready)) && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule
